boron_key_schedule: RTL and testbench
=====================================

# boron_key_schedule

Iterative BORON-80 key schedule. It sits directly upstream of the encryption round datapath and feeds that datapath's 80-bit `round_key` input. It loads one 80-bit master key and emits NUM_ROUNDS+1 round keys, one per valid/ready handshake. The round datapath consumes bits [63:0] of each key. An optional build mode emits the keys in reverse order for decryption.

## Interface
- `NUM_ROUNDS`, default 25: number of cipher rounds. Keys emitted = NUM_ROUNDS+1. Legal range 1..31.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `key_in`  in  80: master key.
- `key_valid`  in  1: `key_in` is valid.
- `key_ready`  out  1: block can accept a key. High only in IDLE.
- `dec_mode`  in  1: sampled with the key. 1 = reverse order. Used only when BORON_KS_DECRYPT_EN is defined.
- `rk_out`  out  80: current round key; registered.
- `rk_valid`  out  1: `rk_out` is valid.
- `rk_ready`  in  1: downstream accepts `rk_out`.
- `rk_index`  out  5: round number of `rk_out`, 0..NUM_ROUNDS.
- `rk_last`  out  1: high with the final key of the sequence.

## Operation
- Forward update F(K, i), with i a 5-bit round counter:
  - K = K rotated left by 13 (80-bit rotate).
  - K[3:0] = S(K[3:0]), where S = E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6 (indexed 0..F).
  - K[63:59] ^= i.
- Round key 0 = master key. Round key i = F(round key i-1, i) for i = 1..NUM_ROUNDS.
- Inverse update G(K, i) (decrypt build only):
  - K[63:59] ^= i.
  - K[3:0] = S⁻¹(K[3:0]), where S⁻¹ = A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B.
  - K = K rotated right by 13.
- State machine:
  - IDLE: `key_ready`=1. On `key_valid && key_ready`, load `key_in` into the key register, set the counter to 0, go to RUN. In decrypt mode, go to PRECOMP instead.
  - PRECOMP: apply F once per cycle with i = counter+1 and increment the counter. When the counter reaches NUM_ROUNDS, go to RUN.
  - RUN: `rk_valid`=1. On `rk_valid && rk_ready`:
    - If this is the last key, go to IDLE.
    - Otherwise, encrypt mode applies F(K, counter+1) and increments the counter. Decrypt mode applies G(K, counter) and decrements the counter.
- `rk_index` = counter.
- `rk_last` = RUN && (encrypt ? counter==NUM_ROUNDS : counter==0).
- `key_valid` outside IDLE is ignored; no key is captured.
- Asserting reset mid-sequence aborts the sequence immediately. No partial sequence resumes.

## Timing
- Reset values: `rk_out`=0, `rk_valid`=0, `rk_index`=0, `rk_last`=0, `key_ready`=1, state IDLE.
- Encrypt: key accepted at edge T. Round key 0 is visible with `rk_valid`=1 after edge T, i.e. during cycle T+1.
- Each accepted handshake presents the next key in the following cycle. With `rk_ready` held high, the full sequence takes NUM_ROUNDS+1 consecutive cycles.
- Backpressure: while `rk_valid && !rk_ready`, `rk_out`, `rk_index` and `rk_last` hold stable.
- After the last handshake: `rk_valid`=0 and `key_ready`=1 in the next cycle. There is no back-to-back overlap of sequences.
- Decrypt: the first key (index NUM_ROUNDS) appears NUM_ROUNDS+1 cycles after key acceptance.

## Configuration
- BORON_KS_DECRYPT_EN defined:
  - PRECOMP state and the G datapath are present.
  - `dec_mode`=1 produces keys in order NUM_ROUNDS down to 0.
- BORON_KS_DECRYPT_EN undefined:
  - `dec_mode` is ignored and treated as 0.
  - PRECOMP and G are absent.
  - Only forward order 0..NUM_ROUNDS is produced.

## Test plan
- Reset check: during and after `rst_n`=0, all outputs are at their reset values. `key_valid` pulsed with `rst_n` low produces no `rk_valid`.
- Zero key, encrypt, `rk_ready`=1:
  - rk0 = 0x0000_0000_0000_0000_0000 with `rk_index`=0.
  - rk1 = 0x0000_0800_0000_0000_000E.
  - 26 keys total, `rk_last` high only with `rk_index`=25, then `key_ready`=1.
- Backpressure: drop `rk_ready` for 5 cycles at `rk_index`=3 -> `rk_out` and `rk_index` stay frozen, then the sequence continues identically to the unstalled run.
- Key during RUN: pulse `key_valid` with a different key at `rk_index`=10 -> ignored; the remaining keys match the original key's sequence.
- Mid-sequence reset at `rk_index`=7, then load key 0xFFFF_FFFF_FFFF_FFFF_FFFF -> a fresh sequence starts at index 0 with rk0 equal to that key.
- With BORON_KS_DECRYPT_EN, zero key, `dec_mode`=1:
  - The first key appears 26 cycles after acceptance with `rk_index`=25.
  - The sequence equals the encrypt sequence reversed, with rk1 = 0x0000_0800_0000_0000_000E.
  - It ends with rk0 = 0 and `rk_last`=1.

Source files
------------

// File: rtl/boron_key_schedule.sv
// BORON-80 iterative key schedule: one master key in, NUM_ROUNDS+1 round keys out.
// Define BORON_KS_DECRYPT_EN to add reverse-order (decryption) key emission.
module boron_key_schedule #(
  parameter int NUM_ROUNDS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [79:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        dec_mode,
  output logic [79:0] rk_out,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [4:0]  rk_index,
  output logic        rk_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd2;
`ifdef BORON_KS_DECRYPT_EN
  localparam logic [1:0] S_PRE  = 2'd1;
`endif
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  logic [1:0]  state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dec_w;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;
      4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;
      4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;
      4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;
      4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [79:0] f_upd(
    input logic [79:0] k,
    input logic [4:0]  i
  );
    logic [79:0] t;
    t = {k[66:0], k[79:67]};
    t[3:0] = sbox(t[3:0]);
    t[63:59] = t[63:59] ^ i;
    return t;
  endfunction

`ifdef BORON_KS_DECRYPT_EN
  logic dec_q, dec_d;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'h3;
      4'h2: y = 4'h9;  4'h3: y = 4'hE;
      4'h4: y = 4'h1;  4'h5: y = 4'hD;
      4'h6: y = 4'hF;  4'h7: y = 4'h4;
      4'h8: y = 4'hC;  4'h9: y = 4'h5;
      4'hA: y = 4'h7;  4'hB: y = 4'h2;
      4'hC: y = 4'h6;  4'hD: y = 4'h8;
      4'hE: y = 4'h0;  default: y = 4'hB;
    endcase
    return y;
  endfunction

  function automatic logic [79:0] g_upd(
    input logic [79:0] k,
    input logic [4:0]  i
  );
    logic [79:0] t;
    t = k;
    t[63:59] = t[63:59] ^ i;
    t[3:0] = sbox_inv(t[3:0]);
    return {t[12:0], t[79:13]};
  endfunction

  assign dec_w = dec_q;
`else
  logic unused_dec_mode;
  assign unused_dec_mode = dec_mode;
  assign dec_w = 1'b0;
`endif

  assign key_ready = (state_q == S_IDLE);
  assign rk_valid  = (state_q == S_RUN);
  assign rk_out    = key_q;
  assign rk_index  = cnt_q;
  assign rk_last   = rk_valid &&
                     (dec_w ? (cnt_q == 5'd0) : (cnt_q == LAST));

  // Next-state: key capture, decrypt precompute, per-handshake key step
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
`ifdef BORON_KS_DECRYPT_EN
    dec_d   = dec_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          key_d   = key_in;
          cnt_d   = 5'd0;
          state_d = S_RUN;
`ifdef BORON_KS_DECRYPT_EN
          dec_d = dec_mode;
          if (dec_mode) state_d = S_PRE;
`endif
        end
      end
`ifdef BORON_KS_DECRYPT_EN
      S_PRE: begin
        key_d = f_upd(key_q, cnt_q + 5'd1);
        cnt_d = cnt_q + 5'd1;
        if ((cnt_q + 5'd1) == LAST) state_d = S_RUN;
      end
`endif
      S_RUN: begin
        if (rk_ready) begin
          if (rk_last) begin
            state_d = S_IDLE;
          end
`ifdef BORON_KS_DECRYPT_EN
          else if (dec_w) begin
            key_d = g_upd(key_q, cnt_q);
            cnt_d = cnt_q - 5'd1;
          end
`endif
          else begin
            key_d = f_upd(key_q, cnt_q + 5'd1);
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
`ifdef BORON_KS_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
`ifdef BORON_KS_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

endmodule

// File: tb/tb_boron_key_schedule.sv
// Directed bench for boron_key_schedule.
// Encrypt runs, stall, ignored key, mid reset; decrypt when enabled.
module tb_boron_key_schedule;

  localparam int NR = 25;
  localparam logic [79:0] RK1 = 80'h0000_0800_0000_0000_000E;
  localparam logic [79:0] RK2 = 80'h0100_1000_0000_0001_C00E;
  localparam logic [79:0] KA  = 80'h0123_4567_89AB_CDEF_1357;
  localparam logic [79:0] KB  = 80'hDEAD_BEEF_0BAD_F00D_5A5A;
  localparam logic [79:0] KF  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SBOX = 64'h6358F02DAC971B4E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [79:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic        dec_mode = 1'b0;
  logic [79:0] rk_out;
  logic        rk_valid;
  logic        rk_ready = 1'b1;
  logic [4:0]  rk_index;
  logic        rk_last;

  int n_run = 0;
  int n_fail = 0;
  logic [79:0] exp_k [0:NR];

  boron_key_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .dec_mode(dec_mode),
    .rk_out(rk_out), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_index(rk_index),
    .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(
    input string       tag,
    input logic [79:0] got,
    input logic [79:0] want
  );
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] ref_f(
    input logic [79:0] k,
    input logic [4:0]  i
  );
    logic [79:0] r;
    logic [63:0] sb;
    sb = SBOX;
    r = (k << 13) | (k >> 67);
    r[3:0] = sb[r[3:0]*4 +: 4];
    r[63:59] = r[63:59] ^ i;
    return r;
  endfunction

  task automatic build(input logic [79:0] k);
    exp_k[0] = k;
    for (int i = 1; i <= NR; i++)
      exp_k[i] = ref_f(exp_k[i-1], 5'(i));
  endtask

  task automatic load(input logic [79:0] k, input logic dm);
    check("kr_idle", 80'(key_ready), 80'd1);
    key_in = k;
    dec_mode = dm;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in = ~k;
    dec_mode = 1'b0;
  endtask

  task automatic run_enc(
    input logic [79:0] k,
    input int stall_at,
    input int inj_at,
    input int rst_at
  );
    build(k);
    load(k, 1'b0);
    for (int i = 0; i <= NR; i++) begin
      check($sformatf("rk%0d", i), rk_out, exp_k[i]);
      check($sformatf("ctl%0d", i),
            80'({rk_valid, rk_last, rk_index}),
            80'({1'b1, i == NR, 5'(i)}));
      if (k == 80'd0 && i == 1) check("rk1_const", rk_out, RK1);
      if (k == 80'd0 && i == 2) check("rk2_const", rk_out, RK2);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl",
              80'({rk_valid, rk_last, rk_index, key_ready}),
              80'({1'b0, 1'b0, 5'd0, 1'b1}));
        check("rst_mid_rk", rk_out, 80'd0);
        tick();
        rst_n = 1'b1;
        return;
      end
      if (i == stall_at) begin
        rk_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_rk", rk_out, exp_k[i]);
          check("stall_idx", 80'({rk_valid, rk_index}),
                80'({1'b1, 5'(i)}));
        end
        rk_ready = 1'b1;
      end
      if (i == inj_at) begin
        check("kr_busy", 80'(key_ready), 80'd0);
        key_in = KB;
        key_valid = 1'b1;
      end
      tick();
      key_valid = 1'b0;
    end
    check("done", 80'({rk_valid, key_ready}), 80'({1'b0, 1'b1}));
  endtask

  initial begin
    // reset held: a key pulse must not start a sequence
    key_in = KA;
    key_valid = 1'b1;
    repeat (3) begin
      tick();
      check("rst_ctl",
            80'({rk_valid, rk_last, rk_index, key_ready}),
            80'({1'b0, 1'b0, 5'd0, 1'b1}));
    end
    check("rst_rk", rk_out, 80'd0);
    key_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst", 80'({rk_valid, key_ready}), 80'({1'b0, 1'b1}));

    run_enc(80'd0, -1, -1, -1);
    run_enc(80'd0, 3, -1, -1);
    run_enc(KA, -1, 10, -1);
    run_enc(KA, -1, -1, 7);
    run_enc(KF, -1, -1, -1);

`ifdef BORON_KS_DECRYPT_EN
    begin
      int c;
      build(80'd0);
      load(80'd0, 1'b1);
      c = 1;
      while (!rk_valid && c < 40) begin
        tick();
        c++;
      end
      check("dec_lat", 80'(c), 80'd26);
      for (int i = NR; i >= 0; i--) begin
        check($sformatf("drk%0d", i), rk_out, exp_k[i]);
        check($sformatf("dctl%0d", i),
              80'({rk_valid, rk_last, rk_index}),
              80'({1'b1, i == 0, 5'(i)}));
        if (i == 1) check("drk1_const", rk_out, RK1);
        tick();
      end
      check("dec_done", 80'({rk_valid, key_ready}),
            80'({1'b0, 1'b1}));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
